// File: rtl/xgbe_mac_tx_arbiter_pkg.sv
// Shared definitions for the XGBE MAC TX arbiter: source indices, one-hot
// grant codes and FSM state encoding.
package xgbe_mac_tx_arbiter_pkg;

  localparam int SRC_AXI_DMA  = 0;
  localparam int SRC_PCIE_DMA = 1;
  localparam int SRC_DOCE     = 2;
  localparam int NUM_SRC      = 3;

  localparam logic [NUM_SRC-1:0] GNT_NONE = 3'b000;
  localparam logic [NUM_SRC-1:0] GNT_AXI  = 3'b001;
  localparam logic [NUM_SRC-1:0] GNT_PCIE = 3'b010;
  localparam logic [NUM_SRC-1:0] GNT_DOCE = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } tx_state_e;

endpackage

// File: rtl/xgbe_mac_tx_arbiter_rr_arb3.sv
// Combinational 3-way round-robin arbiter with optional DoCE strict priority.
// The search starts at the source after last_grant; an invalid last_grant
// code is treated like DoCE so the search then starts at the AXI DMA source.
module rr_arb3
  import xgbe_mac_tx_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] last_grant,
  input  logic               prio_en,
  output logic [NUM_SRC-1:0] gnt,
  output logic               any
);

  // Pick one requester: DoCE first when priority mode is on, else rotate.
  always_comb begin
    gnt = GNT_NONE;
    any = |req;
    if (prio_en && req[SRC_DOCE]) begin
      gnt = GNT_DOCE;
    end else begin
      case (last_grant)
        GNT_AXI: begin
          if (req[SRC_PCIE_DMA])     gnt = GNT_PCIE;
          else if (req[SRC_DOCE])    gnt = GNT_DOCE;
          else if (req[SRC_AXI_DMA]) gnt = GNT_AXI;
          else                       gnt = GNT_NONE;
        end
        GNT_PCIE: begin
          if (req[SRC_DOCE])          gnt = GNT_DOCE;
          else if (req[SRC_AXI_DMA])  gnt = GNT_AXI;
          else if (req[SRC_PCIE_DMA]) gnt = GNT_PCIE;
          else                        gnt = GNT_NONE;
        end
        default: begin
          if (req[SRC_AXI_DMA])       gnt = GNT_AXI;
          else if (req[SRC_PCIE_DMA]) gnt = GNT_PCIE;
          else if (req[SRC_DOCE])     gnt = GNT_DOCE;
          else                        gnt = GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/xgbe_mac_tx_arbiter.sv
// Packet-granular scheduler merging AXI DMA, PCIe DMA and DoCE AXIS streams
// onto the single XGBE MAC TX port. The grant is decided in IDLE, held for a
// whole packet in XFER and dropped after the accepted tlast beat. Source
// tready depends only on the registered grant and MAC tready, never on any
// source tvalid.
module xgbe_mac_tx_arbiter
  import xgbe_mac_tx_arbiter_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 32,
  parameter int DOCE_PRIO = 0
) (
  input  logic                xgemac_clk_156,
  input  logic                xgbe_mac_resetn,
  input  logic [DATA_W-1:0]   axi_dma_to_xgbe_mac_tdata,
  input  logic [DATA_W/8-1:0] axi_dma_to_xgbe_mac_tkeep,
  input  logic                axi_dma_to_xgbe_mac_tlast,
  input  logic                axi_dma_to_xgbe_mac_tvalid,
  output logic                axi_dma_to_xgbe_mac_tready,
  input  logic [DATA_W-1:0]   pcie_dma_to_xgbe_mac_tdata,
  input  logic [DATA_W/8-1:0] pcie_dma_to_xgbe_mac_tkeep,
  input  logic                pcie_dma_to_xgbe_mac_tlast,
  input  logic                pcie_dma_to_xgbe_mac_tvalid,
  output logic                pcie_dma_to_xgbe_mac_tready,
  input  logic [DATA_W-1:0]   doce_to_xgbe_mac_tdata,
  input  logic [DATA_W/8-1:0] doce_to_xgbe_mac_tkeep,
  input  logic                doce_to_xgbe_mac_tlast,
  input  logic                doce_to_xgbe_mac_tvalid,
  output logic                doce_to_xgbe_mac_tready,
  output logic [DATA_W-1:0]   xgbe_mac_axis_tx_tdata,
  output logic [DATA_W/8-1:0] xgbe_mac_axis_tx_tkeep,
  output logic                xgbe_mac_axis_tx_tlast,
  output logic                xgbe_mac_axis_tx_tvalid,
  input  logic                xgbe_mac_axis_tx_tready,
  input  logic                doce_prio_en,
  output logic [CNT_W-1:0]    tx_pkt_cnt_axi_dma,
  output logic [CNT_W-1:0]    tx_pkt_cnt_pcie_dma,
  output logic [CNT_W-1:0]    tx_pkt_cnt_doce
);

  // A nonzero DOCE_PRIO hard-enables DoCE priority on top of the runtime bit.
  localparam logic PRIO_FORCE = (DOCE_PRIO != 0);

  tx_state_e          r_state;
  logic [NUM_SRC-1:0] r_grant;
  logic [NUM_SRC-1:0] r_last_grant;
  logic [CNT_W-1:0]   r_cnt_axi;
  logic [CNT_W-1:0]   r_cnt_pcie;
  logic [CNT_W-1:0]   r_cnt_doce;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_any;
  logic               w_prio_en;
  logic [DATA_W-1:0]  w_tdata;
  logic [DATA_W/8-1:0] w_tkeep;
  logic               w_tlast;
  logic               w_tvalid;
  logic               w_accept_last;

  assign w_req     = {doce_to_xgbe_mac_tvalid, pcie_dma_to_xgbe_mac_tvalid,
                      axi_dma_to_xgbe_mac_tvalid};
  assign w_prio_en = doce_prio_en | PRIO_FORCE;

  rr_arb3 u_rr_arb3 (
    .req        (w_req),
    .last_grant (r_last_grant),
    .prio_en    (w_prio_en),
    .gnt        (w_gnt),
    .any        (w_any)
  );

  // Output mux: r_grant is only nonzero in XFER, so IDLE drives all zeros.
  always_comb begin
    w_tdata  = {DATA_W{1'b0}};
    w_tkeep  = {(DATA_W/8){1'b0}};
    w_tlast  = 1'b0;
    w_tvalid = 1'b0;
    case (r_grant)
      GNT_AXI: begin
        w_tdata  = axi_dma_to_xgbe_mac_tdata;
        w_tkeep  = axi_dma_to_xgbe_mac_tkeep;
        w_tlast  = axi_dma_to_xgbe_mac_tlast;
        w_tvalid = axi_dma_to_xgbe_mac_tvalid;
      end
      GNT_PCIE: begin
        w_tdata  = pcie_dma_to_xgbe_mac_tdata;
        w_tkeep  = pcie_dma_to_xgbe_mac_tkeep;
        w_tlast  = pcie_dma_to_xgbe_mac_tlast;
        w_tvalid = pcie_dma_to_xgbe_mac_tvalid;
      end
      GNT_DOCE: begin
        w_tdata  = doce_to_xgbe_mac_tdata;
        w_tkeep  = doce_to_xgbe_mac_tkeep;
        w_tlast  = doce_to_xgbe_mac_tlast;
        w_tvalid = doce_to_xgbe_mac_tvalid;
      end
      default: begin
        w_tdata  = {DATA_W{1'b0}};
        w_tkeep  = {(DATA_W/8){1'b0}};
        w_tlast  = 1'b0;
        w_tvalid = 1'b0;
      end
    endcase
  end

  assign w_accept_last = w_tvalid & w_tlast & xgbe_mac_axis_tx_tready;

  assign xgbe_mac_axis_tx_tdata      = w_tdata;
  assign xgbe_mac_axis_tx_tkeep      = w_tkeep;
  assign xgbe_mac_axis_tx_tlast      = w_tlast;
  assign xgbe_mac_axis_tx_tvalid     = w_tvalid;
  assign axi_dma_to_xgbe_mac_tready  = r_grant[SRC_AXI_DMA]  & xgbe_mac_axis_tx_tready;
  assign pcie_dma_to_xgbe_mac_tready = r_grant[SRC_PCIE_DMA] & xgbe_mac_axis_tx_tready;
  assign doce_to_xgbe_mac_tready     = r_grant[SRC_DOCE]     & xgbe_mac_axis_tx_tready;
  assign tx_pkt_cnt_axi_dma          = r_cnt_axi;
  assign tx_pkt_cnt_pcie_dma         = r_cnt_pcie;
  assign tx_pkt_cnt_doce             = r_cnt_doce;

  // FSM: grant on IDLE request, release on accepted tlast, count packets.
  always_ff @(posedge xgemac_clk_156 or negedge xgbe_mac_resetn) begin
    if (!xgbe_mac_resetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_NONE;
      r_last_grant <= GNT_DOCE;
      r_cnt_axi    <= {CNT_W{1'b0}};
      r_cnt_pcie   <= {CNT_W{1'b0}};
      r_cnt_doce   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            r_state <= ST_XFER;
          end else begin
            r_grant <= GNT_NONE;
            r_state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (w_accept_last) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_NONE;
            r_last_grant <= r_grant;
            case (r_grant)
              GNT_AXI:  r_cnt_axi  <= r_cnt_axi  + CNT_W'(1);
              GNT_PCIE: r_cnt_pcie <= r_cnt_pcie + CNT_W'(1);
              GNT_DOCE: r_cnt_doce <= r_cnt_doce + CNT_W'(1);
              default:  r_cnt_axi  <= r_cnt_axi;
            endcase
          end else begin
            r_state <= ST_XFER;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgbe_mac_tx_arbiter.sv
// Directed self-checking bench for xgbe_mac_tx_arbiter. A second instance
// with 4-bit counters shares the stimulus and is used for the wrap check.
module tb_xgbe_mac_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata [3];
  logic [7:0]  s_tkeep [3];
  logic [2:0]  s_tlast;
  logic [2:0]  s_tvalid;
  logic        mac_tready;
  logic        prio_en;

  logic [2:0]  w_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid;
  logic [31:0] cnt0, cnt1, cnt2;

  logic [2:0]  q_tready;
  logic [63:0] q_tdata;
  logic [7:0]  q_tkeep;
  logic        q_tlast, q_tvalid;
  logic [3:0]  q_cnt0, q_cnt1, q_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xgbe_mac_tx_arbiter #(.DATA_W(64), .CNT_W(32), .DOCE_PRIO(0)) dut (
    .xgemac_clk_156(clk), .xgbe_mac_resetn(rst_n),
    .axi_dma_to_xgbe_mac_tdata(s_tdata[0]), .axi_dma_to_xgbe_mac_tkeep(s_tkeep[0]),
    .axi_dma_to_xgbe_mac_tlast(s_tlast[0]), .axi_dma_to_xgbe_mac_tvalid(s_tvalid[0]),
    .axi_dma_to_xgbe_mac_tready(w_tready[0]),
    .pcie_dma_to_xgbe_mac_tdata(s_tdata[1]), .pcie_dma_to_xgbe_mac_tkeep(s_tkeep[1]),
    .pcie_dma_to_xgbe_mac_tlast(s_tlast[1]), .pcie_dma_to_xgbe_mac_tvalid(s_tvalid[1]),
    .pcie_dma_to_xgbe_mac_tready(w_tready[1]),
    .doce_to_xgbe_mac_tdata(s_tdata[2]), .doce_to_xgbe_mac_tkeep(s_tkeep[2]),
    .doce_to_xgbe_mac_tlast(s_tlast[2]), .doce_to_xgbe_mac_tvalid(s_tvalid[2]),
    .doce_to_xgbe_mac_tready(w_tready[2]),
    .xgbe_mac_axis_tx_tdata(m_tdata), .xgbe_mac_axis_tx_tkeep(m_tkeep),
    .xgbe_mac_axis_tx_tlast(m_tlast), .xgbe_mac_axis_tx_tvalid(m_tvalid),
    .xgbe_mac_axis_tx_tready(mac_tready), .doce_prio_en(prio_en),
    .tx_pkt_cnt_axi_dma(cnt0), .tx_pkt_cnt_pcie_dma(cnt1), .tx_pkt_cnt_doce(cnt2)
  );

  xgbe_mac_tx_arbiter #(.DATA_W(64), .CNT_W(4), .DOCE_PRIO(0)) dut4 (
    .xgemac_clk_156(clk), .xgbe_mac_resetn(rst_n),
    .axi_dma_to_xgbe_mac_tdata(s_tdata[0]), .axi_dma_to_xgbe_mac_tkeep(s_tkeep[0]),
    .axi_dma_to_xgbe_mac_tlast(s_tlast[0]), .axi_dma_to_xgbe_mac_tvalid(s_tvalid[0]),
    .axi_dma_to_xgbe_mac_tready(q_tready[0]),
    .pcie_dma_to_xgbe_mac_tdata(s_tdata[1]), .pcie_dma_to_xgbe_mac_tkeep(s_tkeep[1]),
    .pcie_dma_to_xgbe_mac_tlast(s_tlast[1]), .pcie_dma_to_xgbe_mac_tvalid(s_tvalid[1]),
    .pcie_dma_to_xgbe_mac_tready(q_tready[1]),
    .doce_to_xgbe_mac_tdata(s_tdata[2]), .doce_to_xgbe_mac_tkeep(s_tkeep[2]),
    .doce_to_xgbe_mac_tlast(s_tlast[2]), .doce_to_xgbe_mac_tvalid(s_tvalid[2]),
    .doce_to_xgbe_mac_tready(q_tready[2]),
    .xgbe_mac_axis_tx_tdata(q_tdata), .xgbe_mac_axis_tx_tkeep(q_tkeep),
    .xgbe_mac_axis_tx_tlast(q_tlast), .xgbe_mac_axis_tx_tvalid(q_tvalid),
    .xgbe_mac_axis_tx_tready(mac_tready), .doce_prio_en(prio_en),
    .tx_pkt_cnt_axi_dma(q_cnt0), .tx_pkt_cnt_pcie_dma(q_cnt1), .tx_pkt_cnt_doce(q_cnt2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = 64'h0;
      s_tkeep[i] = 8'h00;
    end
    s_tlast  = 3'b000;
    s_tvalid = 3'b000;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    clear_inputs();
    mac_tready = 1'b0;
    prio_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp_beat [7] = '{0, 1, 1, 2, 2, 3, 3};

  initial begin
    clear_inputs();
    mac_tready = 1'b0;
    prio_en    = 1'b0;

    // ---- reset state ----
    apply_reset();
    @(negedge clk);
    check_eq("rst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check_eq("rst_tready", {61'h0, w_tready}, 64'h0);
    check_eq("rst_cnts", {cnt0, cnt1 | cnt2}, 64'h0);

    // ---- test 1: src0 3-beat packet ----
    tick();
    mac_tready = 1'b1;
    s_tvalid[0] = 1'b1; s_tdata[0] = 64'hA0; s_tkeep[0] = 8'h3F; s_tlast[0] = 1'b0;
    @(negedge clk);
    check_eq("t1_bubble_tvalid", {63'h0, m_tvalid}, 64'h0);
    check_eq("t1_bubble_tready", {61'h0, w_tready}, 64'h0);
    for (int b = 0; b < 3; b++) begin
      tick();
      s_tdata[0] = 64'hA0 + 64'(b);
      s_tlast[0] = (b == 2);
      @(negedge clk);
      check_eq("t1_tvalid", {63'h0, m_tvalid}, 64'h1);
      check_eq("t1_tdata", m_tdata, 64'hA0 + 64'(b));
      check_eq("t1_tkeep", {56'h0, m_tkeep}, 64'h3F);
      check_eq("t1_tlast", {63'h0, m_tlast}, (b == 2) ? 64'h1 : 64'h0);
      check_eq("t1_tready", {61'h0, w_tready}, 64'h1);
    end
    tick();
    s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
    @(negedge clk);
    check_eq("t1_idle_tvalid", {63'h0, m_tvalid}, 64'h0);
    check_eq("t1_cnt0", {32'h0, cnt0}, 64'h1);

    // ---- test 2: round robin, 12 single-beat packets ----
    apply_reset();
    mac_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = 64'hB0 + 64'(i); s_tkeep[i] = 8'hFF;
    end
    s_tlast = 3'b111; s_tvalid = 3'b111;
    for (int p = 0; p < 12; p++) begin
      @(negedge clk);
      check_eq("t2_bubble", {63'h0, m_tvalid}, 64'h0);
      tick();
      @(negedge clk);
      check_eq("t2_tdata", m_tdata, 64'hB0 + 64'(p % 3));
      check_eq("t2_tready", {61'h0, w_tready}, 64'(3'b001 << (p % 3)));
      tick();
    end
    s_tvalid = 3'b000;
    @(negedge clk);
    check_eq("t2_cnts", {cnt0[15:0], cnt1[15:0], cnt2[15:0]}, 64'h0004_0004_0004);

    // ---- test 3: DoCE strict priority ----
    apply_reset();
    mac_tready = 1'b1; prio_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = 64'hB0 + 64'(i); s_tkeep[i] = 8'hFF;
    end
    s_tlast = 3'b111; s_tvalid = 3'b111;
    for (int p = 0; p < 12; p++) begin
      tick();
      @(negedge clk);
      check_eq("t3_tdata", m_tdata, 64'hB2);
      check_eq("t3_tready", {61'h0, w_tready}, 64'h4);
      tick();
      @(negedge clk);
      check_eq("t3_idle_tready", {61'h0, w_tready}, 64'h0);
    end
    s_tvalid = 3'b000;
    @(negedge clk);
    check_eq("t3_cnts", {cnt0[15:0], cnt1[15:0], cnt2[15:0]}, 64'h0000_0000_000C);

    // ---- test 4: src1 4 beats with MAC backpressure, src0 arrives mid-packet ----
    apply_reset();
    mac_tready = 1'b1;
    s_tvalid[1] = 1'b1; s_tdata[1] = 64'hC0; s_tkeep[1] = 8'h0F; s_tlast[1] = 1'b0;
    @(negedge clk);
    check_eq("t4_bubble", {63'h0, m_tvalid}, 64'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      mac_tready = (k % 2 == 0);
      s_tdata[1] = 64'hC0 + 64'(exp_beat[k]);
      s_tlast[1] = (exp_beat[k] == 3);
      if (k == 1) begin
        s_tvalid[0] = 1'b1; s_tdata[0] = 64'hD0; s_tkeep[0] = 8'hFF; s_tlast[0] = 1'b1;
      end
      @(negedge clk);
      check_eq("t4_tdata", m_tdata, 64'hC0 + 64'(exp_beat[k]));
      check_eq("t4_tlast", {63'h0, m_tlast}, (exp_beat[k] == 3) ? 64'h1 : 64'h0);
      check_eq("t4_tready", {61'h0, w_tready}, (k % 2 == 0) ? 64'h2 : 64'h0);
    end
    tick();
    s_tvalid[1] = 1'b0; s_tlast[1] = 1'b0;
    @(negedge clk);
    check_eq("t4_gap_tvalid", {63'h0, m_tvalid}, 64'h0);
    check_eq("t4_gap_tready", {61'h0, w_tready}, 64'h0);
    check_eq("t4_cnt1", {32'h0, cnt1}, 64'h1);
    tick();
    mac_tready = 1'b1;
    @(negedge clk);
    check_eq("t4_src0_tdata", m_tdata, 64'hD0);
    check_eq("t4_src0_tready", {61'h0, w_tready}, 64'h1);
    tick();
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    check_eq("t4_cnt0", {32'h0, cnt0}, 64'h1);

    // ---- test 5: async reset mid-packet ----
    apply_reset();
    mac_tready = 1'b1;
    s_tvalid[2] = 1'b1; s_tdata[2] = 64'hE0; s_tkeep[2] = 8'hFF; s_tlast[2] = 1'b0;
    tick();
    for (int b = 1; b < 3; b++) begin
      tick();
      s_tdata[2] = 64'hE0 + 64'(b);
    end
    #1;
    check_eq("t5_pre_tdata", m_tdata, 64'hE2);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check_eq("t5_rst_tdata", m_tdata, 64'h0);
    check_eq("t5_rst_tready", {61'h0, w_tready}, 64'h0);
    check_eq("t5_rst_cnt2", {32'h0, cnt2}, 64'h0);
    s_tvalid = 3'b111; s_tlast = 3'b111;
    s_tdata[0] = 64'hF0; s_tdata[1] = 64'hF1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_bubble", {63'h0, m_tvalid}, 64'h0);
    tick();
    @(negedge clk);
    check_eq("t5_first_tdata", m_tdata, 64'hF0);
    check_eq("t5_first_tready", {61'h0, w_tready}, 64'h1);
    tick();
    clear_inputs();

    // ---- test 6: 17 src0 packets, 4-bit counter wraps ----
    apply_reset();
    mac_tready = 1'b1;
    s_tvalid[0] = 1'b1; s_tdata[0] = 64'hE0; s_tkeep[0] = 8'h0F; s_tlast[0] = 1'b1;
    for (int p = 1; p <= 17; p++) begin
      tick();
      @(negedge clk);
      if (p == 1) begin
        check_eq("t6_q_tdata", q_tdata, 64'hE0);
        check_eq("t6_q_ctl", {56'h0, q_tkeep, q_tlast, q_tvalid, q_tready},
                 {56'h0, 8'h0F, 1'b1, 1'b1, 3'b001});
      end
      tick();
      @(negedge clk);
      if (p == 15) check_eq("t6_cnt4_15", {60'h0, q_cnt0}, 64'hF);
      if (p == 16) check_eq("t6_cnt4_16", {60'h0, q_cnt0}, 64'h0);
      if (p == 17) check_eq("t6_cnt4_17", {60'h0, q_cnt0}, 64'h1);
    end
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    check_eq("t6_cnt32", {32'h0, cnt0}, 64'd17);
    check_eq("t6_cnt4_others", {56'h0, q_cnt1, q_cnt2}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
